// File: rtl/sync_ram_bank.sv
// sync_ram_bank
// Single-port synchronous word RAM with per-byte write masking and a
// registered read path. When enabled, it zeroes itself one word per clock
// after reset.
//
// Ports
//   clk          : single clock; all state updates on the rising edge
//   rst          : asynchronous, active-high reset
//   write_enable : write request, sampled only while ready=1
//   read_enable  : read request, sampled only while ready=1
//   address      : word address; addresses >= DEPTH are out of range
//   data_input   : write data
//   byte_enable  : per-lane write mask; bit i covers data_input[8i+7:8i]
//   data_output  : registered read data; holds its value between reads
//   read_valid   : one-cycle strobe, high while data_output is a new result
//   ready        : high when requests are accepted (low while clearing)
module sync_ram_bank #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 65536,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     data_input,
    input  logic [DATA_W/8-1:0]   byte_enable,
    output logic [DATA_W-1:0]     data_output,
    output logic                  read_valid,
    output logic                  ready
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic              ready_q;
    logic              read_valid_q;
    logic [DATA_W-1:0] rdata_q;

    // Write-port controls shared by the clear sweep and normal writes.
    logic              mem_we_d;
    logic [IDX_W-1:0]  mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [NB-1:0]     mem_be_d;

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // The full address is compared so that aliases such as DEPTH+2 never
    // reach the array through the truncated index.
    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    assign idx      = address[IDX_W-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        mem_we_d    = 1'b0;
        mem_waddr_d = idx;
        mem_wdata_d = data_input;
        mem_be_d    = byte_enable;
        if (state_q == ST_CLEAR) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_cnt_q;
            mem_wdata_d = '0;
            mem_be_d    = '1;
        end else if (ready_q && write_enable && in_range) begin
            mem_we_d = 1'b1;
        end
    end

    // NOTE: the array has no reset term; an async reset on every word would
    // block RAM inference. Contents are zeroed only by the CLEAR sweep, and
    // writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (mem_we_d && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_d[b]) begin
                    mem[mem_waddr_d][8*b +: 8] <= mem_wdata_d[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs. The read samples the array before
    // this edge's write lands, which gives read-before-write on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RST_STATE;
            clr_cnt_q    <= '0;
            ready_q      <= (CLEAR_ON_RESET == 0);
            read_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees pre-edge values regardless of statement order.
            read_valid_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (ready_q && read_enable) begin
                        read_valid_q <= 1'b1;
                        rdata_q      <= in_range ? mem[idx] : '0;
                    end
                end
            endcase
        end
    end

    assign data_output = rdata_q;
    assign read_valid  = read_valid_q;
    assign ready       = ready_q;

endmodule

// File: tb/tb_sync_ram_bank.sv
// Directed bench for sync_ram_bank. The main instance uses DEPTH=64 with the
// clear sweep enabled. A second small instance checks the no-clear option.
// Expected read data is queued when a read is issued and compared when
// read_valid appears.
module tb_sync_ram_bank;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DP = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable, read_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_input;
    logic [3:0]    byte_enable;
    logic [DW-1:0] data_output;
    logic          read_valid, ready;

    logic          nc_we, nc_re;
    logic [3:0]    nc_addr;
    logic [DW-1:0] nc_din, nc_dout;
    logic [3:0]    nc_be;
    logic          nc_rv, nc_ready;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sync_ram_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .data_input(data_input), .byte_enable(byte_enable),
        .data_output(data_output), .read_valid(read_valid), .ready(ready)
    );

    sync_ram_bank #(.DATA_W(DW), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(0)) dut_nc (
        .clk(clk), .rst(rst),
        .write_enable(nc_we), .read_enable(nc_re),
        .address(nc_addr), .data_input(nc_din), .byte_enable(nc_be),
        .data_output(nc_dout), .read_valid(nc_rv), .ready(nc_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every read_valid cycle consumes exactly one queued expectation.
    always @(negedge clk) begin
        if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd@%0d", e.addr), data_output, e.data);
            end
        end
    end

    task automatic idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        write_enable = 1'b1;
        read_enable  = 1'b0;
        address      = AW'(a);
        data_input   = d;
        byte_enable  = be;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    // Issue one read; consecutive calls produce back-to-back reads.
    task automatic rd(input int a, input logic [31:0] exp);
        write_enable = 1'b0;
        read_enable  = 1'b1;
        address      = AW'(a);
        exp_q.push_back('{addr: a, data: exp});
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    task automatic rw(input int a, input logic [31:0] d, input logic [31:0] exp);
        write_enable = 1'b1;
        read_enable  = 1'b1;
        address      = AW'(a);
        data_input   = d;
        byte_enable  = 4'hF;
        exp_q.push_back('{addr: a, data: exp});
        @(negedge clk);
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    // Count cycles with ready low, starting from the current negedge.
    task automatic count_clear(output int lo);
        lo = 0;
        while (ready !== 1'b1 && lo < 200) begin
            lo++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lo;

        rst          = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        address      = '0;
        data_input   = '0;
        byte_enable  = '0;
        nc_we = 1'b0; nc_re = 1'b0; nc_addr = '0; nc_din = '0; nc_be = '0;

        // Reset state, with requests presented that must be ignored.
        repeat (3) @(negedge clk);
        read_enable = 1'b1;
        write_enable = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_read_valid", {31'd0, read_valid}, 32'd0);
        check("rst_data_output", data_output, 32'd0);
        check("nc_rst_ready", {31'd0, nc_ready}, 32'd1);

        // Release reset while a write to word 60 and a read are held through
        // CLEAR; neither may take effect.
        address      = AW'(60);
        data_input   = 32'hDEADBEEF;
        byte_enable  = 4'hF;
        rst          = 1'b0;
        count_clear(lo);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check("clear_cycles", lo, DP);
        check("nc_ready_after_rst", {31'd0, nc_ready}, 32'd1);

        // Every word reads zero after the sweep, read back-to-back.
        for (int a = 0; a < DP; a++) rd(a, 32'd0);
        idle();

        // Basic writes; 66 is beyond DEPTH, so it is ignored and reads zero,
        // and it must not alias onto word 2.
        wr(6, 32'd20, 4'hF);
        rd(6, 32'd20);
        wr(66, 32'd20, 4'hF);
        rd(66, 32'd0);
        rd(2, 32'd0);
        wr(55, 32'd1, 4'hF);
        rd(55, 32'd1);
        wr(127, 32'h12345678, 4'hF);
        rd(63, 32'd0);

        // Byte-lane merge.
        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h11223344, 4'b0101);
        rd(5, 32'hAA22CC44);

        // All-zero byte_enable is a no-op.
        wr(8, 32'hFFFFFFFF, 4'h0);
        rd(8, 32'd0);

        // Same-address read and write: old data out, new data stored.
        wr(7, 32'h9, 4'hF);
        rw(7, 32'h5, 32'h9);
        rd(7, 32'h5);

        // data_output holds after the strobe drops.
        rd(5, 32'hAA22CC44);
        idle();
        idle();
        check("hold_read_valid", {31'd0, read_valid}, 32'd0);
        check("hold_data_output", data_output, 32'hAA22CC44);

        // Reset mid-operation clears the outputs immediately.
        rst = 1'b1;
        #1;
        check("midop_rst_data_output", data_output, 32'd0);
        check("midop_rst_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset again at CLEAR cycle 30; the sweep restarts in full.
        repeat (30) @(negedge clk);
        check("clear30_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("clear30_rst_read_valid", {31'd0, read_valid}, 32'd0);
        check("clear30_rst_data_output", data_output, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_clear(lo);
        check("clear_cycles_restart", lo, DP);
        rd(5, 32'd0);
        rd(7, 32'd0);
        idle();

        // No-clear instance accepts requests straight away.
        nc_we = 1'b1; nc_addr = 4'd3; nc_din = 32'h00001234; nc_be = 4'hF;
        @(negedge clk);
        nc_we = 1'b0; nc_re = 1'b1;
        @(negedge clk);
        nc_re = 1'b0;
        check("nc_read_valid", {31'd0, nc_rv}, 32'd1);
        check("nc_data_output", nc_dout, 32'h00001234);

        // Every issued read must have produced its strobe.
        repeat (3) idle();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
